// File: rtl/alu_op_seq_pkg.sv
// Shared op codes, ALU select encodings, FSM states and the ALU control vector
// for the ALU op sequencer.
package alu_op_seq_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_COMP  = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_DIFF  = 4'd4;
    localparam logic [3:0] OP_SHLL  = 4'd5;
    localparam logic [3:0] OP_SHRL  = 4'd6;
    localparam logic [3:0] OP_SHRA  = 4'd7;
    localparam logic [3:0] OP_SHLLV = 4'd8;
    localparam logic [3:0] OP_SHRLV = 4'd9;
    localparam logic [3:0] OP_SHRAV = 4'd10;
    localparam logic [3:0] OP_SUB   = 4'd11;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    localparam logic [1:0] PO_ADD  = 2'd0;
    localparam logic [1:0] PO_AND  = 2'd1;
    localparam logic [1:0] PO_XOR  = 2'd2;
    localparam logic [1:0] PO_DIFF = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        addr_src_b_sel;
        logic [1:0]  primary_out_sel;
        logic [1:0]  shift_type;
        logic [4:0]  shift_amnt;
        logic        shifter_enbl;
    } alu_ctrl_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational map from a latched request to the ALU control vector.
// Illegal codes yield an all-zero vector with the illegal flag set.
module alu_op_decode
    import alu_op_seq_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     a,
    input  logic [31:0]     b,
    input  logic [4:0]      shamt,
    output alu_ctrl_t       ctrl,
    output logic            illegal
);

    always_comb begin
        ctrl         = '0;
        ctrl.a       = a;
        ctrl.b       = b;
        illegal      = 1'b0;
        case (op)
            OP_W'(OP_ADD):  ctrl.primary_out_sel = PO_ADD;
            OP_W'(OP_COMP): begin
                // -b is formed as 0 + ~b + 1 on the adder path
                ctrl.a              = '0;
                ctrl.addr_src_b_sel = 1'b1;
            end
            OP_W'(OP_AND):  ctrl.primary_out_sel = PO_AND;
            OP_W'(OP_XOR):  ctrl.primary_out_sel = PO_XOR;
            OP_W'(OP_DIFF): ctrl.primary_out_sel = PO_DIFF;
            OP_W'(OP_SHLL), OP_W'(OP_SHRL), OP_W'(OP_SHRA): begin
                ctrl.shifter_enbl = 1'b1;
                ctrl.shift_amnt   = shamt;
                ctrl.shift_type   = (op == OP_W'(OP_SHLL)) ? SH_SLL :
                                    (op == OP_W'(OP_SHRL)) ? SH_SRL : SH_SRA;
            end
            OP_W'(OP_SHLLV), OP_W'(OP_SHRLV), OP_W'(OP_SHRAV): begin
                ctrl.shifter_enbl = 1'b1;
                ctrl.shift_amnt   = b[4:0];
                ctrl.shift_type   = (op == OP_W'(OP_SHLLV)) ? SH_SLL :
                                    (op == OP_W'(OP_SHRLV)) ? SH_SRL : SH_SRA;
            end
            OP_W'(OP_SUB):  ctrl.addr_src_b_sel = 1'b1;
            default: begin
                ctrl    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller driving the combinational ALU with a settle window.
// Optional perf counters (perf_ops, perf_illegal) under ALU_OP_SEQ_PERF_CNT_EN.
module alu_op_sequencer
    import alu_op_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int OP_W          = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [31:0]     req_a,
    input  logic [31:0]     req_b,
    input  logic [4:0]      req_shamt,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_result,
    output logic            rsp_carry,
    output logic            rsp_zero,
    output logic            rsp_msb,
    output logic            rsp_err,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic            alu_addr_src_b_sel,
    output logic [1:0]      alu_primary_out_sel,
    output logic [1:0]      alu_shift_type,
    output logic [4:0]      alu_shift_amnt,
    output logic            alu_shifter_enbl,
    input  logic [31:0]     alu_out,
    input  logic            alu_c_out,
    input  logic            alu_zero,
    input  logic            alu_msb
`ifdef ALU_OP_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]     perf_ops,
    output logic [7:0]      perf_illegal
`endif
);

    localparam int CNT_W = 4;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_op_sequencer: SETTLE_CYCLES must be in 1..15");
    end
    if (OP_W < 4) begin : g_bad_op_w
        $error("alu_op_sequencer: OP_W must be at least 4");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [OP_W-1:0]  op_q;
    logic [31:0]      a_q, b_q, result_q;
    logic [4:0]       shamt_q;
    logic             carry_q, zero_q, msb_q, err_q;
    logic             req_illegal, dec_illegal;
    alu_ctrl_t        ctrl, alu_drv;

    assign req_illegal = (req_op > OP_W'(OP_SUB));

    alu_op_decode #(.OP_W(OP_W)) u_decode (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .shamt   (shamt_q),
        .ctrl    (ctrl),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = req_illegal ? ST_RESP : ST_EXEC;
            ST_EXEC: if (cnt_q == '0) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shamt_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            msb_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    op_q    <= req_op;
                    a_q     <= req_a;
                    b_q     <= req_b;
                    shamt_q <= req_shamt;
                    cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
                    err_q   <= req_illegal;
                    if (req_illegal) begin
                        result_q <= '0;
                        carry_q  <= 1'b0;
                        zero_q   <= 1'b0;
                        msb_q    <= 1'b0;
                    end
                end
                ST_EXEC: if (cnt_q == '0) begin
                    result_q <= alu_out;
                    carry_q  <= alu_c_out;
                    zero_q   <= alu_zero;
                    msb_q    <= alu_msb;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outside EXEC the ALU sees the ADD path with zero operands
    assign alu_drv = (state_q == ST_EXEC && !dec_illegal) ? ctrl : '0;

    assign alu_a               = alu_drv.a;
    assign alu_b               = alu_drv.b;
    assign alu_addr_src_b_sel  = alu_drv.addr_src_b_sel;
    assign alu_primary_out_sel = alu_drv.primary_out_sel;
    assign alu_shift_type      = alu_drv.shift_type;
    assign alu_shift_amnt      = alu_drv.shift_amnt;
    assign alu_shifter_enbl    = alu_drv.shifter_enbl;

    assign req_ready  = rst_n && (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = result_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;
    assign rsp_msb    = msb_q;
    assign rsp_err    = err_q;

`ifdef ALU_OP_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops     <= '0;
            perf_illegal <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (err_q) begin
                if (perf_illegal != '1) perf_illegal <= perf_illegal + 8'd1;
            end else if (perf_ops != '1) begin
                perf_ops <= perf_ops + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Random and directed bench for alu_op_sequencer: two DUTs (settle 1 and 4)
// share requests and are scored against an arithmetic reference of each op.
module tb_alu_op_sequencer;
    import alu_op_seq_pkg::*;

    localparam int S0 = 1;
    localparam int S1 = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_shamt;
    logic [1:0]  req_ready, rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_msb, rsp_err;
    logic [31:0] rsp_result [2];
    logic [31:0] alu_a [2], alu_b [2], alu_out [2];
    logic [1:0]  alu_sub, alu_sen, alu_c_out, alu_zero, alu_msb;
    logic [1:0]  alu_prim [2], alu_st [2];
    logic [4:0]  alu_amt [2];
`ifdef ALU_OP_SEQ_PERF_CNT_EN
    logic [15:0] perf_ops [2];
    logic [7:0]  perf_illegal [2];
`endif

    int checks = 0;
    int errors = 0;
    int n_ops  = 0;
    int n_ill  = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.SETTLE_CYCLES(S0), .OP_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
        .rsp_carry(rsp_carry[0]), .rsp_zero(rsp_zero[0]), .rsp_msb(rsp_msb[0]), .rsp_err(rsp_err[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_addr_src_b_sel(alu_sub[0]),
        .alu_primary_out_sel(alu_prim[0]), .alu_shift_type(alu_st[0]), .alu_shift_amnt(alu_amt[0]),
        .alu_shifter_enbl(alu_sen[0]), .alu_out(alu_out[0]), .alu_c_out(alu_c_out[0]),
        .alu_zero(alu_zero[0]),
`ifdef ALU_OP_SEQ_PERF_CNT_EN
        .perf_ops(perf_ops[0]), .perf_illegal(perf_illegal[0]),
`endif
        .alu_msb(alu_msb[0])
    );

    alu_op_sequencer #(.SETTLE_CYCLES(S1), .OP_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
        .rsp_carry(rsp_carry[1]), .rsp_zero(rsp_zero[1]), .rsp_msb(rsp_msb[1]), .rsp_err(rsp_err[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_addr_src_b_sel(alu_sub[1]),
        .alu_primary_out_sel(alu_prim[1]), .alu_shift_type(alu_st[1]), .alu_shift_amnt(alu_amt[1]),
        .alu_shifter_enbl(alu_sen[1]), .alu_out(alu_out[1]), .alu_c_out(alu_c_out[1]),
        .alu_zero(alu_zero[1]),
`ifdef ALU_OP_SEQ_PERF_CNT_EN
        .perf_ops(perf_ops[1]), .perf_illegal(perf_illegal[1]),
`endif
        .alu_msb(alu_msb[1])
    );

    // Combinational ALU as seen by the sequencer: {carry, zero, msb, result}
    function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub, input logic [1:0] prim,
                                           input logic [1:0] st, input logic [4:0] amt,
                                           input logic sen);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        s = {1'b0, a} + {1'b0, (sub ? ~b : b)} + 33'(sub);
        c = 1'b0;
        if (sen) begin
            case (st)
                2'd0:    r = a << amt;
                2'd1:    r = a >> amt;
                2'd2:    r = 32'($signed(a) >>> amt);
                default: r = '0;
            endcase
        end else begin
            case (prim)
                2'd0:    begin r = s[31:0]; c = s[32]; end
                2'd1:    r = a & b;
                2'd2:    r = a ^ b;
                default: r = a & ~b;
            endcase
        end
        return {c, (r == 32'd0), r[31], r};
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++)
            {alu_c_out[i], alu_zero[i], alu_msb[i], alu_out[i]} =
                alu_fn(alu_a[i], alu_b[i], alu_sub[i], alu_prim[i], alu_st[i], alu_amt[i], alu_sen[i]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // What each op means arithmetically
    task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] sh, output logic [31:0] r, output logic c,
                             output logic e);
        logic [32:0] w;
        r = '0; c = 1'b0; e = 1'b0;
        case (op)
            4'd0:  begin w = 33'(a) + 33'(b); r = w[31:0]; c = w[32]; end
            4'd1:  begin r = 32'd0 - b; c = (b == 32'd0); end
            4'd2:  r = a & b;
            4'd3:  r = a ^ b;
            4'd4:  r = a & ~b;
            4'd5:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = 32'($signed(a) >>> sh);
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = 32'($signed(a) >>> b[4:0]);
            4'd11: begin r = a - b; c = (a >= b); end
            default: e = 1'b1;
        endcase
    endtask

    // Issue one request to both DUTs; hold0/hold1 = cycles each consumer stalls
    task automatic run_txn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input int hold0, input int hold1);
        logic [31:0] er, ea, snap [2];
        logic [4:0]  eamt;
        logic        ec, ee, ez, em, es;
        int          ph [2], held [2], hold [2], lat [2];
        int          cyc, w;
        ref_model(op, a, b, sh, er, ec, ee);
        ez   = !ee && (er == 32'd0);
        em   = er[31];
        ea   = (op == 4'd1) ? 32'd0 : a;
        es   = (op >= 4'd5 && op <= 4'd10);
        eamt = (op >= 4'd5 && op <= 4'd7) ? sh : (op >= 4'd8 && op <= 4'd10) ? b[4:0] : 5'd0;
        lat[0] = ee ? 0 : S0;
        lat[1] = ee ? 0 : S1;
        hold[0] = hold0;
        hold[1] = hold1;
        if (ee) n_ill++; else n_ops++;

        w = 0;
        while (req_ready != 2'b11 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd3);

        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_shamt = sh;
        @(posedge clk); #1;
        req_valid = 1'b0;
        ph = '{0, 0};
        held = '{0, 0};
        cyc = 0;
        while (1) begin
            for (int i = 0; i < 2; i++) begin
                if (ph[i] == 2) begin
                    rsp_ready[i] = 1'b0;
                    chk($sformatf("rsp_drop%0d", i), 32'(rsp_valid[i]), 32'd0);
                    chk($sformatf("ready_back%0d", i), 32'(req_ready[i]), 32'd1);
                    ph[i] = 3;
                end else if (ph[i] == 1) begin
                    chk($sformatf("hold_valid%0d", i), 32'(rsp_valid[i]), 32'd1);
                    chk($sformatf("hold_result%0d", i), rsp_result[i], snap[i]);
                    chk($sformatf("hold_noready%0d", i), 32'(req_ready[i]), 32'd0);
                    held[i]++;
                end else if (ph[i] == 0) begin
                    if (rsp_valid[i]) begin
                        chk($sformatf("latency%0d op%0d", i, op), 32'(cyc), 32'(lat[i]));
                        chk($sformatf("result%0d op%0d", i, op), rsp_result[i], er);
                        chk($sformatf("carry%0d op%0d", i, op), 32'(rsp_carry[i]), 32'(ec));
                        chk($sformatf("zero%0d op%0d", i, op), 32'(rsp_zero[i]), 32'(ez));
                        chk($sformatf("msb%0d op%0d", i, op), 32'(rsp_msb[i]), 32'(em));
                        chk($sformatf("err%0d op%0d", i, op), 32'(rsp_err[i]), 32'(ee));
                        chk($sformatf("alu_idle%0d", i),
                            32'(|{alu_a[i], alu_b[i], alu_sub[i], alu_prim[i], alu_st[i],
                                  alu_amt[i], alu_sen[i]}), 32'd0);
                        snap[i] = rsp_result[i];
                        ph[i] = 1;
                    end else if (!ee) begin
                        chk($sformatf("exec_a%0d op%0d", i, op), alu_a[i], ea);
                        chk($sformatf("exec_sen%0d op%0d", i, op), 32'(alu_sen[i]), 32'(es));
                        chk($sformatf("exec_amt%0d op%0d", i, op), 32'(alu_amt[i]), 32'(eamt));
                    end
                end
                if (ph[i] == 1 && held[i] >= hold[i]) begin
                    rsp_ready[i] = 1'b1;
                    ph[i] = 2;
                end
            end
            if (ph[0] == 3 && ph[1] == 3) break;
            if (cyc >= 100) begin
                chk("txn_timeout", 32'(ph[0] * 4 + ph[1]), 32'd15);
                rsp_ready = 2'b00;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        req_shamt = '0; rsp_ready = 2'b00;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(req_ready), 32'd3);
        chk("post_rst_result", rsp_result[0] | rsp_result[1], 32'd0);
        chk("post_rst_alu_a", alu_a[0] | alu_a[1], 32'd0);

        run_txn(4'd0, 32'h5, 32'h3, 5'd0, 0, 0);
        run_txn(4'd1, 32'h55, 32'h1, 5'd0, 1, 0);
        run_txn(4'd11, 32'h1234_5678, 32'h1234_5678, 5'd0, 0, 2);
        run_txn(4'd10, 32'h8000_0000, 32'h4, 5'd9, 0, 0);
        run_txn(4'd5, 32'h1, 32'h0, 5'd31, 0, 0);
        run_txn(4'd6, 32'hdead_beef, 32'h7, 5'd0, 0, 0);
        run_txn(4'd13, 32'h1, 32'h2, 5'd3, 0, 0);
        run_txn(4'd0, 32'h1, 32'h1, 5'd0, 0, 0);
        run_txn(4'd4, 32'hf0f0_ffff, 32'h0ff0_00f0, 5'd0, 5, 5);
        run_txn(4'd3, 32'hffff_0000, 32'h00ff_00ff, 5'd0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_txn(4'($urandom_range(0, 15)), a, b, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
`ifdef ALU_OP_SEQ_PERF_CNT_EN
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("perf_ops%0d", i), 32'(perf_ops[i]), 32'(n_ops));
            chk($sformatf("perf_illegal%0d", i), 32'(perf_illegal[i]), 32'(n_ill));
        end
`endif

        // Reset while the slow DUT is mid-EXEC
        rsp_ready = 2'b11;
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'h7; req_b = 32'h9; req_shamt = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_exec_a", alu_a[1], 32'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_result", rsp_result[0] | rsp_result[1], 32'd0);
        chk("mid_rst_flags", 32'({rsp_carry, rsp_zero, rsp_msb, rsp_err}), 32'd0);
        chk("mid_rst_alu", 32'(|{alu_a[0], alu_a[1], alu_b[0], alu_b[1], alu_sub, alu_sen,
                                 alu_prim[0], alu_prim[1], alu_st[0], alu_st[1],
                                 alu_amt[0], alu_amt[1]}), 32'd0);
`ifdef ALU_OP_SEQ_PERF_CNT_EN
        chk("mid_rst_perf", 32'(perf_ops[0]) | 32'(perf_ops[1]) |
                            32'(perf_illegal[0]) | 32'(perf_illegal[1]), 32'd0);
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; rsp_ready = 2'b00;
        repeat (6) @(posedge clk);
        #1;
        chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        chk("ready_after_rst", 32'(req_ready), 32'd3);
        n_ops = 0; n_ill = 0;
        run_txn(4'd0, 32'h10, 32'h20, 5'd0, 0, 0);
`ifdef ALU_OP_SEQ_PERF_CNT_EN
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("perf_ops_after%0d", i), 32'(perf_ops[i]), 32'd1);
            chk($sformatf("perf_ill_after%0d", i), 32'(perf_illegal[i]), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sits between the miniRISC execute stage and the 32-bit combinational ALU.
- Accepts one decoded ALU operation per request over a valid/ready handshake.
- Drives the ALU control lines and operands, then holds them for a programmable settle time so the ripple adder and shifter can resolve.
- Captures the result and flags, and returns them over a valid/ready response handshake.

Parameters:
- SETTLE_CYCLES, 1: cycles the ALU controls are held before capture. Legal range 1..15; elaboration error outside that range.
- OP_W, 4: width of the op code.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  OP_W  op code (see Behaviour)
- req_a  in  32  operand rs
- req_b  in  32  operand rt
- req_shamt  in  5  immediate shift amount
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_result  out  32  captured ALU result
- rsp_carry  out  1  captured ALU carry-out
- rsp_zero  out  1  captured ALU zero flag
- rsp_msb  out  1  captured ALU MSB
- rsp_err  out  1  illegal op code
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_addr_src_b_sel  out  1  invert b and force carry-in
- alu_primary_out_sel  out  2  00 ADD, 01 AND, 10 XOR, 11 DIFF
- alu_shift_type  out  2  00 SLL, 01 SRL, 10 SRA
- alu_shift_amnt  out  5  shift distance
- alu_shifter_enbl  out  1  select shifter path
- alu_out  in  32  ALU result
- alu_c_out  in  1  ALU carry
- alu_zero  in  1  ALU zero
- alu_msb  in  1  ALU MSB

Behaviour:
- Op codes:
  - 0 ADD: a+b
  - 1 COMP: alu_a=0, b inverted, carry-in 1, i.e. -b
  - 2 AND
  - 3 XOR
  - 4 DIFF
  - 5 SHLL, 6 SHRL, 7 SHRA: amount = req_shamt
  - 8 SHLLV, 9 SHRLV, 10 SHRAV: amount = req_b[4:0]
  - 11 SUB: a + ~b + 1
  - 12..15 illegal
- For shift ops, alu_a = req_a and alu_shifter_enbl = 1. For all other ops, alu_shifter_enbl = 0 and alu_shift_amnt = 0.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid at an edge: latch op, operands and amount.
  - Legal op: go to EXEC with settle counter = SETTLE_CYCLES-1.
  - Illegal op: go directly to RESP with rsp_err = 1, rsp_result = 0, all flags 0.
- EXEC:
  - req_ready = 0.
  - ALU outputs driven from the latched request and held stable for every EXEC cycle.
  - Counter decrements each cycle. At the edge where it reads 0, alu_out and the flags are registered and the FSM goes to RESP.
  - rsp_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- RESP:
  - rsp_valid = 1; rsp_* outputs stay stable until taken.
  - On rsp_ready: go to IDLE.
  - No request is accepted in the same cycle. Minimum issue interval is SETTLE_CYCLES+2 cycles.
- Whenever the FSM is not in EXEC, all alu_* outputs are 0, i.e. the ADD path with zero operands.
- rsp_err is cleared on the next accept.
- Shift amount 0 produces rsp_result = req_a.
- Reset:
  - Asynchronous assertion from any state returns the FSM to IDLE. All outputs go to 0 except req_ready, which is 1 once reset is deasserted.
  - Any in-flight op is discarded with no response.
- rsp_ready held high while in IDLE or EXEC has no effect.

Optional Feature:
- ALU_OP_SEQ_PERF_CNT_EN defined:
  - Adds outputs perf_ops (16 bit), counting completed legal responses.
  - Adds perf_illegal (8 bit), counting completed illegal responses.
  - Both counters increment on the rsp_valid && rsp_ready edge, saturate at all-ones, and are cleared by reset.
- Undefined: those ports and counters do not exist.

Decomposition:
- Package alu_op_seq_pkg holds:
  - op code localparams
  - shift type codes (SLL/SRL/SRA)
  - primary output select codes (ADD/AND/XOR/DIFF)
  - FSM state encoding
- One combinational sub-module, alu_op_decode, maps latched op/a/b/shamt to the alu_* control vector plus an illegal flag. The FSM and capture registers stay in alu_op_sequencer.

Test Plan:
1. ADD a=0x0000_0005, b=0x0000_0003, SETTLE_CYCLES=1 -> rsp_valid one edge after accept; result 0x8, zero=0, carry=0.
2. COMP b=0x0000_0001 -> result 0xFFFF_FFFF, msb=1. SUB a=b=0x1234_5678 -> result 0, zero=1, carry=1.
3. SHRAV a=0x8000_0000, b=0x0000_0004 -> result 0xF800_0000. SHLL a=0x1, shamt=31 -> 0x8000_0000.
4. Illegal op 13 -> rsp_err=1, result 0, no EXEC cycle. Then ADD 1+1 -> err cleared, result 2.
5. SETTLE_CYCLES=4:
   - alu_* outputs stable for 4 cycles.
   - rsp_ready held low for 5 cycles -> response held stable and req_ready stays 0.
   - Release -> back-to-back request accepted next cycle.
6. Assert rst_n low mid-EXEC -> all outputs 0 immediately, no response. The request after reset completes normally. With ALU_OP_SEQ_PERF_CNT_EN defined, counters read 0 after reset and 1 after the completed op.
